// File: rtl/irq_ctrl.sv
// irq_ctrl: trap source arbiter in front of the microcoded decoder (irq lines, fault, syscall, reti, continue).
// Define IRQ_CTRL_SYNC_EN to put two-flop synchronizers on irq_in and cont_in ahead of edge detection.
module irq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic       fault_in,
  input  logic       cont_in,
  input  logic       SYSCALL,
  input  logic       RETI,
  input  logic [3:0] state,
  input  logic       mask_we,
  input  logic [7:0] mask_wd,
  input  logic       ie_we,
  input  logic       ie_wd,
  output logic       irq_r,
  output logic       fault_r,
  output logic       cont_r,
  output logic [3:0] cause,
  output logic       ie,
  output logic       in_isr,
  output logic       dfault,
  output logic [7:0] mask
);

  logic [7:0] irq_q, irq_d, irq_rise, pend, pend_m, ack_line;
  logic       cont_q, cont_d, cont_rise;
  logic       sys_d, reti_d, sys_rise, reti_rise;
  logic       swi, flt;
  logic       ack, ack_flt, ack_swi;
  logic [3:0] win_code;

`ifdef IRQ_CTRL_SYNC_EN
  logic [7:0] irq_s1;
  logic       cont_s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_s1  <= 8'h00;
      irq_q   <= 8'h00;
      cont_s1 <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      irq_s1  <= irq_in;
      irq_q   <= irq_s1;
      cont_s1 <= cont_in;
      cont_q  <= cont_s1;
    end
  end
`else
  assign irq_q  = irq_in;
  assign cont_q = cont_in;
`endif

  assign irq_rise  = irq_q & ~irq_d;
  assign cont_rise = cont_q & ~cont_d;
  assign sys_rise  = SYSCALL & ~sys_d;
  assign reti_rise = RETI & ~reti_d;

  assign pend_m  = pend & mask;
  assign irq_r   = (((|pend_m) & ie) | swi) & ~in_isr & ~flt;
  assign fault_r = flt;

  // Fault outranks syscall, which outranks the lowest-numbered unmasked line.
  assign ack      = (state == 4'd0) & (flt | irq_r);
  assign ack_flt  = ack & flt;
  assign ack_swi  = ack & ~flt & swi;
  assign ack_line = (ack & ~flt & ~swi) ? (pend_m & (~pend_m + 8'd1)) : 8'h00;

  always_comb begin
    win_code = 4'd0;
    if (flt) begin
      win_code = 4'd9;
    end else if (swi) begin
      win_code = 4'd8;
    end else begin
      for (int i = 7; i >= 0; i--)
        if (pend_m[i]) win_code = 4'(i);
    end
  end

  // New edges are OR-ed in after the acknowledge clear, so a set in the same cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_d  <= 8'h00;
      cont_d <= 1'b0;
      sys_d  <= 1'b0;
      reti_d <= 1'b0;
      cont_r <= 1'b0;
      pend   <= 8'h00;
      swi    <= 1'b0;
      flt    <= 1'b0;
      mask   <= 8'h00;
      cause  <= 4'd0;
      ie     <= 1'b0;
      in_isr <= 1'b0;
      dfault <= 1'b0;
    end else begin
      irq_d  <= irq_q;
      cont_d <= cont_q;
      sys_d  <= SYSCALL;
      reti_d <= RETI;
      cont_r <= cont_rise;
      pend   <= (pend & ~ack_line) | irq_rise;
      swi    <= (swi & ~ack_swi) | sys_rise;
      flt    <= fault_in | (flt & ~ack_flt);
      if (mask_we)
        mask <= mask_wd;
      if (ack) begin
        cause  <= win_code;
        ie     <= 1'b0;
        in_isr <= 1'b1;
        if (ack_flt & in_isr)
          dfault <= 1'b1;
      end else if (reti_rise) begin
        in_isr <= 1'b0;
        ie     <= 1'b1;
      end else if (ie_we) begin
        ie <= ie_wd;
      end
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl; a cycle-level behavioural model predicts every output after each posedge.
// Directed trap scenarios are followed by constrained random traffic.
module tb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_in = 8'h00;
  logic       fault_in = 1'b0, cont_in = 1'b0, SYSCALL = 1'b0, RETI = 1'b0;
  logic [3:0] state = 4'd7;
  logic       mask_we = 1'b0, ie_we = 1'b0, ie_wd = 1'b0;
  logic [7:0] mask_wd = 8'h00;
  logic       irq_r, fault_r, cont_r, ie, in_isr, dfault;
  logic [3:0] cause;
  logic [7:0] mask;

  irq_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .fault_in(fault_in), .cont_in(cont_in),
    .SYSCALL(SYSCALL), .RETI(RETI), .state(state), .mask_we(mask_we), .mask_wd(mask_wd),
    .ie_we(ie_we), .ie_wd(ie_wd), .irq_r(irq_r), .fault_r(fault_r), .cont_r(cont_r),
    .cause(cause), .ie(ie), .in_isr(in_isr), .dfault(dfault), .mask(mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irq_r, fault_r, cont_r;
    logic [3:0] cause;
    logic       ie, in_isr, dfault;
    logic [7:0] mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Shadow stimulus, copied onto the DUT pins at each negedge.
  logic       s_reset = 1'b1, s_fault = 1'b0, s_cont = 1'b0, s_sys = 1'b0, s_reti = 1'b0;
  logic       s_mwe = 1'b0, s_iwe = 1'b0, s_iwd = 1'b0;
  logic [7:0] s_irq = 8'h00, s_mwd = 8'h00;
  logic [3:0] s_state = 4'd7;

  logic [7:0] m_pend = 8'h00, m_mask = 8'h00;
  logic       m_swi = 0, m_flt = 0, m_ie = 0, m_isr = 0, m_dfault = 0, m_cont = 0;
  logic       m_sys = 0, m_reti = 0;
  logic [3:0] m_cause = 4'd0;
  logic [7:0] irq_hist [0:3] = '{default: 8'h00};
  logic       cont_hist [0:3] = '{default: 1'b0};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Reference model: one call per posedge, using the input values just driven.
  task automatic model_step();
    exp_t       e;
    logic [7:0] rise, pm;
    logic       crise, srise, rrise, req, ack;
    int         code;
    if (reset) begin
      m_pend = 0; m_mask = 0; m_swi = 0; m_flt = 0; m_ie = 0; m_isr = 0;
      m_dfault = 0; m_cont = 0; m_sys = 0; m_reti = 0; m_cause = 0;
      for (int j = 0; j < 4; j++) begin
        irq_hist[j] = 8'h00;
        cont_hist[j] = 1'b0;
      end
    end else begin
      for (int j = 3; j > 0; j--) begin
        irq_hist[j] = irq_hist[j-1];
        cont_hist[j] = cont_hist[j-1];
      end
      irq_hist[0] = irq_in;
      cont_hist[0] = cont_in;
      rise  = irq_hist[D] & ~irq_hist[D+1];
      crise = cont_hist[D] & ~cont_hist[D+1];
      srise = SYSCALL & ~m_sys;
      rrise = RETI & ~m_reti;
      m_sys = SYSCALL;
      m_reti = RETI;
      pm  = m_pend & m_mask;
      req = (((pm != 0) && m_ie) || m_swi) && !m_isr && !m_flt;
      ack = (state == 4'd0) && (m_flt || req);
      if (ack) begin
        if (m_flt) begin
          code = 9;
          m_flt = 0;
          if (m_isr) m_dfault = 1;
        end else if (m_swi) begin
          code = 8;
          m_swi = 0;
        end else begin
          code = 0;
          while (!pm[code]) code++;
          m_pend[code] = 1'b0;
        end
        m_cause = 4'(code);
        m_ie = 0;
        m_isr = 1;
      end else if (rrise) begin
        m_isr = 0;
        m_ie = 1;
      end else if (ie_we) begin
        m_ie = ie_wd;
      end
      m_pend = m_pend | rise;
      if (srise) m_swi = 1;
      if (fault_in) m_flt = 1;
      if (mask_we) m_mask = mask_wd;
      m_cont = crise;
    end
    e.irq_r   = ((((m_pend & m_mask) != 0) && m_ie) || m_swi) && !m_isr && !m_flt;
    e.fault_r = m_flt;
    e.cont_r  = m_cont;
    e.cause   = m_cause;
    e.ie      = m_ie;
    e.in_isr  = m_isr;
    e.dfault  = m_dfault;
    e.mask    = m_mask;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    reset = s_reset; irq_in = s_irq; fault_in = s_fault; cont_in = s_cont;
    SYSCALL = s_sys; RETI = s_reti; state = s_state;
    mask_we = s_mwe; mask_wd = s_mwd; ie_we = s_iwe; ie_wd = s_iwd;
    model_step();
  endtask

  task automatic tick(input int n);
    repeat (n) apply_stimulus();
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_output("irq_r", irq_r, mon_e.irq_r);
        check_output("fault_r", fault_r, mon_e.fault_r);
        check_output("cont_r", cont_r, mon_e.cont_r);
        check_output("cause", cause, mon_e.cause);
        check_output("ie", ie, mon_e.ie);
        check_output("in_isr", in_isr, mon_e.in_isr);
        check_output("dfault", dfault, mon_e.dfault);
        check_output("mask", mask, mon_e.mask);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    s_reset = 1; tick(2);
    s_reset = 0; s_state = 7; tick(1);

    // Single line trap with mask 0x05.
    s_mwe = 1; s_mwd = 8'h05; s_iwe = 1; s_iwd = 1; tick(1);
    s_mwe = 0; s_iwe = 0;
    s_irq = 8'h04; tick(D + 1); sample();
    check_output("s1_irq_r", irq_r, 1);
    s_state = 0; tick(1); sample();
    check_output("s1_cause", cause, 2);
    check_output("s1_ie", ie, 0);
    check_output("s1_in_isr", in_isr, 1);
    check_output("s1_irq_r_ack", irq_r, 0);
    s_state = 7; s_irq = 8'h00; tick(4);
    s_reti = 1; tick(1); s_reti = 0; tick(1);

    // Two lines at once: line 0 first, line 2 held pending.
    s_irq = 8'h05; tick(D + 1);
    s_state = 0; tick(1); sample();
    check_output("s2_cause0", cause, 0);
    s_state = 7; s_irq = 8'h00; s_reti = 1; tick(1); sample();
    check_output("s2_irq_r_again", irq_r, 1);
    s_reti = 0; s_state = 0; tick(1); sample();
    check_output("s2_cause2", cause, 2);
    s_state = 7; tick(1); s_reti = 1; tick(1); s_reti = 0; tick(1);

    // Fault trap, then a second fault inside the handler.
    s_iwe = 1; s_iwd = 0; tick(1); s_iwe = 0;
    s_fault = 1; tick(1); sample();
    check_output("s3_fault_r", fault_r, 1);
    s_fault = 0; s_state = 0; tick(1); sample();
    check_output("s3_cause", cause, 9);
    check_output("s3_fault_r_clr", fault_r, 0);
    s_state = 7; s_fault = 1; tick(1);
    s_fault = 0; s_state = 0; tick(1); sample();
    check_output("s3_dfault", dfault, 1);
    s_state = 7; s_reti = 1; tick(1); s_reti = 0; tick(1);

    // Long SYSCALL gives one trap; a second one waits for RETI.
    s_iwe = 1; s_iwd = 0; tick(1); s_iwe = 0;
    s_sys = 1; tick(2);
    s_state = 0; tick(1); sample();
    check_output("s4_cause", cause, 8);
    check_output("s4_in_isr", in_isr, 1);
    s_state = 7; tick(1); s_sys = 0; tick(1);
    s_sys = 1; tick(1);
    s_sys = 0; s_state = 0; tick(1); sample();
    check_output("s4_swi_held", irq_r, 0);
    s_state = 7; s_reti = 1; tick(1); sample();
    check_output("s4_swi_after_reti", irq_r, 1);
    s_reti = 0; s_state = 0; tick(1); sample();
    check_output("s4_cause2", cause, 8);
    check_output("s4_in_isr2", in_isr, 1);
    s_state = 7; s_reti = 1; tick(1); s_reti = 0; tick(1);

    // Continue button held for ten cycles.
    s_cont = 1; cnt = 0;
    repeat (10) begin
      tick(1); sample();
      if (cont_r) cnt++;
    end
    check_output("s5_cont_pulses", cnt, 1);
    s_cont = 0; tick(1);

    // Reset while a handler is active.
    s_sys = 1; tick(1); s_sys = 0; s_state = 0; tick(1); s_state = 7; tick(1);
    s_reset = 1; tick(1); #1;
    check_output("rst_irq_r", irq_r, 0);
    check_output("rst_fault_r", fault_r, 0);
    check_output("rst_cont_r", cont_r, 0);
    check_output("rst_cause", cause, 0);
    check_output("rst_ie", ie, 0);
    check_output("rst_in_isr", in_isr, 0);
    check_output("rst_dfault", dfault, 0);
    check_output("rst_mask", mask, 0);
    tick(1); s_reset = 0; tick(1);

    // Constrained random traffic.
    repeat (600) begin
      if ($urandom_range(0, 5) == 0) s_irq = s_irq ^ 8'(1 << $urandom_range(0, 7));
      s_fault = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) s_cont = ~s_cont;
      if ($urandom_range(0, 5) == 0) s_sys = ~s_sys;
      if ($urandom_range(0, 7) == 0) s_reti = ~s_reti;
      s_state = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      s_mwe = ($urandom_range(0, 9) == 0);
      s_mwd = 8'($urandom);
      s_iwe = ($urandom_range(0, 7) == 0);
      s_iwd = 1'($urandom);
      s_reset = ($urandom_range(0, 249) == 0);
      if (s_fault) s_state = 4'($urandom_range(1, 15));
      if (s_state == 4'd0) s_sys = SYSCALL;
      if (s_iwe && s_reti && !RETI) s_iwe = 0;
      tick(1);
    end

    s_reset = 0; s_mwe = 0; s_iwe = 0; s_fault = 0; s_state = 7;
    tick(2); sample();
    check_output("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
